// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: MIPS 5-stage hazard/stall/flush sequencer with dmem timeout halt; optional stall counter under PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic freeze, adv, err_c, halt_c, hazard, lu, br, jp;
  always_comb begin
    state_d = state_q;
    wait_cnt_d = wait_cnt_q;
    freeze = 1'b0;
    adv = 1'b0;
    err_c = 1'b0;
    halt_c = 1'b0;
    if (state_q == RUN) begin
      if (dmem_req && !dmem_ready) begin
        freeze = 1'b1;
        state_d = MEM_WAIT;
        wait_cnt_d = WW'(1);
      end else begin
        adv = 1'b1;
      end
    end else if (state_q == MEM_WAIT) begin
      if (dmem_ready || !dmem_req) begin
        adv = 1'b1;
        state_d = RUN;
        wait_cnt_d = '0;
      end else if (wait_cnt_q == LAST) begin
        freeze = 1'b1;
        err_c = 1'b1;
        state_d = HALT;
      end else begin
        freeze = 1'b1;
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else begin
      freeze = 1'b1;
      halt_c = 1'b1;
    end
    // branch beats load-use, load-use beats jump
    hazard = ex_memread && ex_rt != 5'd0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    br = adv && ex_branch_taken;
    lu = adv && !ex_branch_taken && hazard;
    jp = adv && !ex_branch_taken && !hazard && id_jump;
    pc_we = !rst && !freeze && !lu;
    ifid_we = !rst && !freeze && !lu;
    idex_we = !rst && !freeze;
    exmem_we = !rst && !freeze;
    memwb_bubble = !rst && freeze;
    ifid_flush = !rst && (br || jp);
    idex_flush = !rst && (br || lu);
    mem_err = !rst && err_c;
    halted = !rst && halt_c;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = (!pc_we && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule
